// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle sequencer: states, mux selects, ALU ops, opcodes.
// The control word is decoded from state alone; data-dependent strobes are gated at the top.
package cpu_defs;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_REGA = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;
    localparam logic [1:0] SRCA_SP   = 2'd3;

    localparam logic [1:0] SRCB_REGB     = 2'd0;
    localparam logic [1:0] SRCB_CONST2   = 2'd1;
    localparam logic [1:0] SRCB_SIMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SHL1 = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_PASSB = 2'd3;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_I    = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BR   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       pcwrite;   // unconditional PC load
        logic       fetch;     // IRWrite/PCWrite follow MemReady
        logic       branch;    // PCWrite follows Zero
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       busy;
        logic       fault;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_FETCH: begin
                c.srcb    = SRCB_CONST2;
                c.memread = 1'b1;
                c.fetch   = 1'b1;
            end
            S_DECODE:   c.srcb = SRCB_IMM_SHL1;
            S_EXEC_R: begin
                c.srca  = SRCA_REGA;
                c.aluop = ALUOP_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.srca = SRCA_REGA;
                c.srcb = SRCB_SIMM;
            end
            S_WB_ALU:   c.regwrite = 1'b1;
            S_MEM_RD:   c.memread  = 1'b1;
            S_WB_MEM: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEM_WR:   c.memwrite = 1'b1;
            S_BRANCH: begin
                c.srca   = SRCA_REGA;
                c.aluop  = ALUOP_SUB;
                c.branch = 1'b1;
            end
            S_JUMP: begin
                c.srca    = SRCA_ZERO;
                c.srcb    = SRCB_IMM_SHL1;
                c.aluop   = ALUOP_PASSB;
                c.pcwrite = 1'b1;
            end
            S_FAULT:    c.fault = 1'b1;
            default:    c.busy  = (s != S_IDLE);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the last permitted wait cycle.
// Latency: count updates on the clock edge; expired is combinational from the count.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [3:0] LAST = 4'(LIMIT - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (clr)
            cnt <= 4'd0;
        else if (en)
            cnt <= cnt + 4'd1;
    end

    // A wait cycle seen with cnt at LAST is the one that would reach LIMIT.
    assign expired = (cnt == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle control FSM driving ALU operand muxes, ALUOp and datapath write enables.
// Control word is registered alongside the state; only fetch/branch PC strobes see live inputs.
module alu_sequencer
    import cpu_defs::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Run,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                MemToReg,
    output logic                Busy,
    output logic                Fault
);
    state_t state;
    state_t nxt;
    state_t done_nxt;
    ctrl_t  ctl;
    logic   waiting;
    logic   tmr_expired;

    assign done_nxt = Run ? S_FETCH : S_IDLE;
    assign waiting  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (Run) nxt = S_FETCH;
            S_FETCH: begin
                if (MemReady)         nxt = S_DECODE;
                else if (tmr_expired) nxt = S_FAULT;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_R:         nxt = S_EXEC_R;
                    OP_I:         nxt = S_EXEC_I;
                    OP_LD, OP_ST: nxt = S_MEM_ADDR;
                    OP_BR:        nxt = S_BRANCH;
                    OP_JMP:       nxt = S_JUMP;
                    OP_HALT:      nxt = S_IDLE;
                    default:      nxt = S_FAULT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_MEM_ADDR: nxt = (Opcode == OP_ST) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (MemReady)         nxt = S_WB_MEM;
                else if (tmr_expired) nxt = S_FAULT;
            end
            S_MEM_WR: begin
                if (MemReady)         nxt = done_nxt;
                else if (tmr_expired) nxt = S_FAULT;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: nxt = done_nxt;
            S_FAULT:    nxt = S_FAULT;
            default:    nxt = S_FAULT;
        endcase
    end

    // Any state change restarts the wait count, so each access gets a full budget.
    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (Reset),
        .clr     (nxt != state),
        .en      (waiting && !MemReady),
        .expired (tmr_expired)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= decode_ctrl(nxt);
        end
    end

    assign ALUSrcA  = ctl.srca;
    assign ALUSrcB  = ctl.srcb;
    assign ALUOp    = ctl.aluop;
    assign IRWrite  = ctl.fetch & MemReady;
    assign PCWrite  = ctl.pcwrite | (ctl.fetch & MemReady) | (ctl.branch & Zero);
    assign MemRead  = ctl.memread;
    assign MemWrite = ctl.memwrite;
    assign RegWrite = ctl.regwrite;
    assign MemToReg = ctl.memtoreg;
    assign Busy     = ctl.busy;
    assign Fault    = ctl.fault;

endmodule
